// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, four shift/rotate modes, serial in/out,
// and a burst engine that performs a programmed number of shifts with busy/done.
module univ_shift_reg #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             sh,
    input  logic [1:0]       mode,
    input  logic             di,
    input  logic             start,
    input  logic [CW-1:0]    cnt,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [WIDTH-1:0] shift_q;
    logic            shift_so;

    // Next register value and escaping bit for one step in the live mode.
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        shift_q  = q;
        shift_so = 1'b0;
        case (mode)
            2'b00: begin
                shift_q  = {di, q[WIDTH-1:1]};
                shift_so = q[0];
            end
            2'b01: begin
                shift_q  = {q[WIDTH-2:0], di};
                shift_so = q[WIDTH-1];
            end
            2'b10: begin
                shift_q  = {q[0], q[WIDTH-1:1]};
                shift_so = q[0];
            end
            default: begin
                shift_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                shift_so = q[WIDTH-1];
            end
        endcase
    end

    // Edge priority: clr > ld > burst step > start > sh > hold.
    // NOTE: non-blocking assignments so all state updates use pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            count <= '0;
            q     <= '0;
            so    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ld) begin
                q     <= d;
                state <= IDLE;
                busy  <= 1'b0;
                count <= '0;
            end else if (state == SHIFT) begin
                q  <= shift_q;
                so <= shift_so;
                if (count != '0) begin
                    count <= count - CW'(1);
                end
                if (count <= CW'(1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else if (start) begin
                if (cnt != '0) begin
                    state <= SHIFT;
                    count <= cnt;
                    busy  <= 1'b1;
                end else begin
                    done <= 1'b1;
                end
            end else if (sh) begin
                q  <= shift_q;
                so <= shift_so;
            end
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus randomized traffic checked
// against a behavioural model kept in integer arithmetic.
module tb_univ_shift_reg;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk;
    logic          clr, ld, sh, di, start;
    logic [W-1:0]  d;
    logic [1:0]    mode;
    logic [CW-1:0] cnt;
    logic [W-1:0]  q;
    logic          so, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    int m_q = 0, m_so = 0, m_busy = 0, m_done = 0, m_left = 0;

    univ_shift_reg #(.WIDTH(W), .CW(CW)) dut (
        .clk(clk), .clr(clr), .ld(ld), .d(d), .sh(sh), .mode(mode), .di(di),
        .start(start), .cnt(cnt), .q(q), .so(so), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_shift();
        int mask;
        int out;
        mask = (1 << W) - 1;
        if (mode == 2'd0 || mode == 2'd2) begin
            out  = m_q & 1;
            m_q  = (m_q >> 1) | (((mode == 2'd0) ? int'(di) : out) << (W - 1));
        end else begin
            out  = (m_q >> (W - 1)) & 1;
            m_q  = ((m_q << 1) & mask) | ((mode == 2'd1) ? int'(di) : out);
        end
        m_so = out;
    endtask

    task automatic model_edge();
        if (clr) begin
            m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (ld) begin
                m_q = int'(d); m_busy = 0; m_left = 0;
            end else if (m_busy != 0) begin
                model_shift();
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                end
            end else if (start) begin
                if (cnt != 0) begin
                    m_left = int'(cnt); m_busy = 1;
                end else begin
                    m_done = 1;
                end
            end else if (sh) begin
                model_shift();
            end
        end
    endtask

    // Apply one clock edge with the inputs currently driven; sample 1 ns later.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; ld = 0; sh = 0; start = 0; di = 0; mode = 2'd0; d = '0; cnt = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        clr = 1; ld = 1; sh = 1; start = 1; d = 4'hF; cnt = 3'd5; di = 1; mode = 2'd3;
        tick();
        clr = 0; ld = 0; sh = 0; start = 0;
        n_checks++; if (q !== 4'b0000) begin n_fail++; $display("FAIL reset_q: got %b expected 0000", q); end
        n_checks++; if (so !== 1'b0) begin n_fail++; $display("FAIL reset_so: got %b expected 0", so); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_load_shift_right();
        logic [W-1:0] exp_q [4] = '{4'b1011, 4'b1101, 4'b1110, 4'b1111};
        logic         exp_so[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        idle_inputs();
        ld = 1; d = 4'b0110;
        tick();
        n_checks++; if (q !== 4'b0110) begin n_fail++; $display("FAIL load_q: got %b expected 0110", q); end
        ld = 0; sh = 1; mode = 2'd0; di = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL shr_q[%0d]: got %b expected %b", i, q, exp_q[i]); end
            n_checks++; if (so !== exp_so[i]) begin n_fail++; $display("FAIL shr_so[%0d]: got %b expected %b", i, so, exp_so[i]); end
        end
        sh = 0;
    endtask

    task automatic test_rotate_left();
        logic [W-1:0] exp_q [2] = '{4'b0011, 4'b0110};
        logic         exp_so[2] = '{1'b1, 1'b0};
        idle_inputs();
        ld = 1; d = 4'b1001;
        tick();
        ld = 0; sh = 1; mode = 2'd3;
        for (int i = 0; i < 2; i++) begin
            di = (i == 0);
            tick();
            n_checks++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL rol_q[%0d]: got %b expected %b", i, q, exp_q[i]); end
            n_checks++; if (so !== exp_so[i]) begin n_fail++; $display("FAIL rol_so[%0d]: got %b expected %b", i, so, exp_so[i]); end
        end
        sh = 0;
    endtask

    task automatic test_burst();
        logic [W-1:0] exp_q   [3] = '{4'b0010, 4'b0100, 4'b1000};
        logic         exp_busy[3] = '{1'b1, 1'b1, 1'b0};
        logic         exp_done[3] = '{1'b0, 1'b0, 1'b1};
        idle_inputs();
        ld = 1; d = 4'b0001;
        tick();
        ld = 0; mode = 2'd1; di = 0; start = 1; cnt = 3'd3;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL burst_start_busy: got %b expected 1", busy); end
        n_checks++; if (q !== 4'b0001) begin n_fail++; $display("FAIL burst_start_noshift: got %b expected 0001", q); end
        // Keep start asserted with a different count while busy: must be ignored.
        cnt = 3'd7;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) start = 0;
            tick();
            n_checks++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL burst_q[%0d]: got %b expected %b", i, q, exp_q[i]); end
            n_checks++; if (busy !== exp_busy[i]) begin n_fail++; $display("FAIL burst_busy[%0d]: got %b expected %b", i, busy, exp_busy[i]); end
            n_checks++; if (done !== exp_done[i]) begin n_fail++; $display("FAIL burst_done[%0d]: got %b expected %b", i, done, exp_done[i]); end
        end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL burst_done_once: got %b expected 0", done); end
        n_checks++; if (q !== 4'b1000) begin n_fail++; $display("FAIL burst_hold_q: got %b expected 1000", q); end
    endtask

    task automatic test_cnt_zero();
        idle_inputs();
        start = 1; cnt = 3'd0; mode = 2'd0;
        tick();
        start = 0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL cnt0_done: got %b expected 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cnt0_busy: got %b expected 0", busy); end
        n_checks++; if (q !== 4'b1000) begin n_fail++; $display("FAIL cnt0_q: got %b expected 1000", q); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL cnt0_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_load_abort();
        idle_inputs();
        start = 1; cnt = 3'd5; mode = 2'd0;
        tick();
        start = 0;
        tick();
        ld = 1; d = 4'b1010;
        tick();
        ld = 0;
        n_checks++; if (q !== 4'b1010) begin n_fail++; $display("FAIL abort_q: got %b expected 1010", q); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (done !== 1'b0 || q !== 4'b1010) begin n_fail++; $display("FAIL abort_after[%0d]: got done=%b q=%b expected done=0 q=1010", i, done, q); end
        end
    endtask

    task automatic test_sh_during_burst();
        logic [W-1:0] exp_q[3] = '{4'b1010, 4'b0101, 4'b1010};
        idle_inputs();
        mode = 2'd2; sh = 1; start = 1; cnt = 3'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 0;
            n_checks++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL shburst_q[%0d]: got %b expected %b", i, q, exp_q[i]); end
        end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL shburst_end: got done=%b busy=%b expected done=1 busy=0", done, busy); end
        tick();
        sh = 0;
        n_checks++; if (q !== 4'b0101) begin n_fail++; $display("FAIL shburst_idle_shift: got %b expected 0101", q); end
    endtask

    task automatic test_clr_mid_burst();
        idle_inputs();
        start = 1; cnt = 3'd4; mode = 2'd1; di = 1;
        tick();
        start = 0;
        tick();
        clr = 1;
        tick();
        clr = 0;
        n_checks++; if ({q, so, busy, done} !== 7'b0) begin n_fail++; $display("FAIL clr_mid: got q=%b so=%b busy=%b done=%b expected all 0", q, so, busy, done); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_mid_after[%0d]: got done=%b busy=%b expected 0 0", i, done, busy); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr   = ($urandom_range(40) == 0);
            ld    = ($urandom_range(12) == 0);
            start = ($urandom_range(5) == 0);
            sh    = $urandom_range(1);
            di    = $urandom_range(1);
            mode  = 2'($urandom_range(3));
            d     = W'($urandom);
            cnt   = CW'($urandom);
            tick();
            n_checks++;
            if (q !== W'(m_q) || so !== 1'(m_so) || busy !== 1'(m_busy) || done !== 1'(m_done)) begin
                n_fail++;
                $display("FAIL random[%0d]: got q=%b so=%b busy=%b done=%b expected q=%b so=%0d busy=%0d done=%0d",
                         i, q, so, busy, done, W'(m_q), m_so, m_busy, m_done);
            end
            n_checks++;
            if (busy === 1'b1 && done === 1'b1) begin n_fail++; $display("FAIL random_busy_done[%0d]: got both 1 expected not both", i); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_shift_right();
        test_rotate_left();
        test_burst();
        test_cnt_zero();
        test_load_abort();
        test_sh_during_burst();
        test_clr_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
